// File: rtl/piso_y_if.sv
// piso_y_if: frame-in / word-out handshake bundle for the piso_y collector.
// Ports: p_in_v/p_in/p_in_ready (parallel frame), s_out_v/s_out/s_out_ready/s_out_last (serial word), ovf (drop pulse).
// Modports: master = collector side (drives serial stream), slave = environment side (producer + consumer).
interface piso_y_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUM     = 8
);
  logic                           p_in_v;
  logic [PE_NUM*DATA_WIDTH*2-1:0] p_in;
  logic                           p_in_ready;
  logic                           s_out_ready;
  logic                           s_out_v;
  logic [DATA_WIDTH*2-1:0]        s_out;
  logic                           s_out_last;
  logic                           ovf;

  modport master (
    input  p_in_v, p_in, s_out_ready,
    output p_in_ready, s_out_v, s_out, s_out_last, ovf
  );

  modport slave (
    output p_in_v, p_in, s_out_ready,
    input  p_in_ready, s_out_v, s_out, s_out_last, ovf
  );
endinterface

// File: rtl/piso_y.sv
// piso_y: captures a PE_NUM-lane frame of complex words in one cycle and streams lane 0..PE_NUM-1 out.
// Latency: frame accepted at edge N shows lane 0 on s_out after edge N; one word per transfer, no bubble between frames.
// Backpressure: s_out/cnt hold while s_out_ready low; frames offered when not ready are dropped with a one-cycle ovf pulse.
// Ports: clk, rst (async active-high), bus (piso_y_if.master); optional drop_cnt[15:0] when PISO_DROP_CNT_EN is defined
// (saturating count of ovf events, cleared only by rst).
module piso_y #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_NUM     = 8
) (
  input  logic      clk,
  input  logic      rst,
  piso_y_if.master  bus
`ifdef PISO_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(PE_NUM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PE_NUM - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q [PE_NUM];
  logic [WORD_W-1:0] sr_d [PE_NUM];
  logic              ovf_q, ovf_d;
  logic              last;
  logic              accept;

  assign last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

  // Ready is combinational so a new frame can be taken on the same edge as the final word leaves.
  assign bus.p_in_ready = !rst && ((state_q == IDLE) || (last && bus.s_out_ready));
  assign accept         = bus.p_in_v && bus.p_in_ready;

  assign bus.s_out_v    = (state_q == SHIFT);
  // Lane 0 of the register is the output word; it drains to zero after the last shift so s_out idles at 0.
  assign bus.s_out      = sr_q[0];
  assign bus.s_out_last = last;
  assign bus.ovf        = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ovf_d   = bus.p_in_v && !bus.p_in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int k = 0; k < PE_NUM; k++) sr_d[k] = bus.p_in[k*WORD_W +: WORD_W];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_out_ready) begin
          for (int k = 0; k < PE_NUM - 1; k++) sr_d[k] = sr_q[k+1];
          sr_d[PE_NUM-1] = '0;
          if (last) begin
            cnt_d = '0;
            if (accept) begin
              // Back-to-back frame: overwrite the shifted contents, stay streaming.
              for (int k = 0; k < PE_NUM; k++) sr_d[k] = bus.p_in[k*WORD_W +: WORD_W];
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < PE_NUM; k++) sr_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < PE_NUM; k++) sr_q[k] <= sr_d[k];
    end
  end

`ifdef PISO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_piso_y.sv
module tb_piso_y;
  localparam int DW = 16;
  localparam int PN = 8;
  localparam int WW = 2 * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  piso_y_if #(.DATA_WIDTH(DW), .PE_NUM(PN)) bus ();

`ifdef PISO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  piso_y #(.DATA_WIDTH(DW), .PE_NUM(PN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PISO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  function automatic logic [PN*WW-1:0] frame(input int base);
    logic [PN*WW-1:0] f;
    f = '0;
    for (int k = 0; k < PN; k++) f[k*WW +: WW] = WW'(base + k);
    return f;
  endfunction

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int base);
    bus.p_in   = frame(base);
    bus.p_in_v = 1'b1;
    tick();
    bus.p_in_v = 1'b0;
  endtask

  task automatic test_reset();
    bus.p_in_v = 1'b0; bus.p_in = '0; bus.s_out_ready = 1'b1; rst = 1'b1;
    #100;
    @(negedge clk);
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL rst_s_out_v got %b want 0", bus.s_out_v); else pass_cnt++;
    chk_cnt++; if (bus.s_out !== '0) $display("FAIL rst_s_out got %0d want 0", bus.s_out); else pass_cnt++;
    chk_cnt++; if (bus.s_out_last !== 1'b0) $display("FAIL rst_last got %b want 0", bus.s_out_last); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", bus.ovf); else pass_cnt++;
    chk_cnt++; if (bus.p_in_ready !== 1'b0) $display("FAIL rst_p_in_ready got %b want 0", bus.p_in_ready); else pass_cnt++;
`ifdef PISO_DROP_CNT_EN
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); else pass_cnt++;
`endif
    rst = 1'b0;
    #1;
    chk_cnt++; if (bus.p_in_ready !== 1'b1) $display("FAIL idle_p_in_ready got %b want 1", bus.p_in_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_basic();
    bus.s_out_ready = 1'b1;
    load(1);
    for (int i = 0; i < PN; i++) begin
      chk_cnt++; if (bus.s_out_v !== 1'b1) $display("FAIL basic_v[%0d] got %b want 1", i, bus.s_out_v); else pass_cnt++;
      chk_cnt++; if (bus.s_out !== WW'(i + 1)) $display("FAIL basic_word[%0d] got %0d want %0d", i, bus.s_out, i + 1); else pass_cnt++;
      chk_cnt++; if (bus.s_out_last !== (i == PN - 1)) $display("FAIL basic_last[%0d] got %b want %b", i, bus.s_out_last, i == PN - 1); else pass_cnt++;
      if (i == 3) begin
        chk_cnt++; if (bus.p_in_ready !== 1'b0) $display("FAIL basic_midready got %b want 0", bus.p_in_ready); else pass_cnt++;
      end
      tick();
    end
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL basic_end_v got %b want 0", bus.s_out_v); else pass_cnt++;
    chk_cnt++; if (bus.p_in_ready !== 1'b1) $display("FAIL basic_end_ready got %b want 1", bus.p_in_ready); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001; // ready sequence 1,0,0,1 repeating (bit 3 first)
    logic [WW-1:0] held;
    int exp_w = 1;
    int xfers = 0;
    int cyc = 0;
    bus.s_out_ready = 1'b1;
    load(1);
    while (exp_w <= PN && cyc < 100) begin
      bus.s_out_ready = pat[3 - (cyc % 4)];
      if (bus.s_out_ready) begin
        chk_cnt++; if (bus.s_out !== WW'(exp_w) || bus.s_out_v !== 1'b1) $display("FAIL bp_word got %0d want %0d", bus.s_out, exp_w); else pass_cnt++;
        chk_cnt++; if (bus.s_out_last !== (exp_w == PN)) $display("FAIL bp_last[%0d] got %b want %b", exp_w, bus.s_out_last, exp_w == PN); else pass_cnt++;
        exp_w++; xfers++;
        tick();
      end else begin
        held = bus.s_out;
        tick();
        chk_cnt++; if (bus.s_out !== held || bus.s_out_v !== 1'b1) $display("FAIL bp_hold got %0d want %0d", bus.s_out, held); else pass_cnt++;
      end
      cyc++;
    end
    chk_cnt++; if (xfers != PN) $display("FAIL bp_xfers got %0d want %0d", xfers, PN); else pass_cnt++;
    bus.s_out_ready = 1'b1;
    #1;
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL bp_end_v got %b want 0", bus.s_out_v); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.s_out_ready = 1'b1;
    load(1);
    for (int i = 0; i < 2 * PN; i++) begin
      chk_cnt++; if (bus.s_out_v !== 1'b1 || bus.s_out !== WW'(i + 1)) $display("FAIL b2b_word[%0d] got %0d want %0d", i, bus.s_out, i + 1); else pass_cnt++;
      chk_cnt++; if (bus.s_out_last !== (i == PN - 1 || i == 2 * PN - 1)) $display("FAIL b2b_last[%0d] got %b", i, bus.s_out_last); else pass_cnt++;
      bus.p_in_v = (i == PN - 1);
      bus.p_in   = frame(PN + 1);
      if (i == PN - 1) begin
        #1;
        chk_cnt++; if (bus.p_in_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", bus.p_in_ready); else pass_cnt++;
      end
      tick();
    end
    bus.p_in_v = 1'b0;
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL b2b_end_v got %b want 0", bus.s_out_v); else pass_cnt++;
  endtask

  task automatic test_overrun();
    bus.s_out_ready = 1'b1;
    load(1);
    for (int i = 0; i < PN; i++) begin
      chk_cnt++; if (bus.s_out_v !== 1'b1 || bus.s_out !== WW'(i + 1)) $display("FAIL ovr_word[%0d] got %0d want %0d", i, bus.s_out, i + 1); else pass_cnt++;
      if (i == 3) begin
        chk_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovr_pulse got %b want 1", bus.ovf); else pass_cnt++;
      end
      if (i == 4) begin
        chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovr_pulse_end got %b want 0", bus.ovf); else pass_cnt++;
      end
      bus.p_in_v = (i == 2);
      bus.p_in   = frame(100);
      tick();
    end
    bus.p_in_v = 1'b0;
    chk_cnt++; if (bus.s_out_v !== 1'b0 || bus.s_out !== '0) $display("FAIL ovr_end got v=%b w=%0d want v=0 w=0", bus.s_out_v, bus.s_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.s_out_ready = 1'b1;
    load(1);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL rmid_v got %b want 0", bus.s_out_v); else pass_cnt++;
    chk_cnt++; if (bus.s_out !== '0) $display("FAIL rmid_word got %0d want 0", bus.s_out); else pass_cnt++;
    chk_cnt++; if (bus.p_in_ready !== 1'b0) $display("FAIL rmid_ready got %b want 0", bus.p_in_ready); else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    load(21);
    for (int i = 0; i < PN; i++) begin
      chk_cnt++; if (bus.s_out_v !== 1'b1 || bus.s_out !== WW'(21 + i)) $display("FAIL rmid_word[%0d] got %0d want %0d", i, bus.s_out, 21 + i); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (bus.s_out_v !== 1'b0) $display("FAIL rmid_end_v got %b want 0", bus.s_out_v); else pass_cnt++;
  endtask

`ifdef PISO_DROP_CNT_EN
  task automatic test_drop_cnt();
    bus.s_out_ready = 1'b1;
    load(1);
    bus.s_out_ready = 1'b0;
    bus.p_in = frame(100);
    bus.p_in_v = 1'b1;
    repeat (3) tick();
    bus.p_in_v = 1'b0;
    chk_cnt++; if (drop_cnt !== 16'd3) $display("FAIL drop_three got %0d want 3", drop_cnt); else pass_cnt++;
    bus.p_in_v = 1'b1;
    repeat (65537) tick();
    bus.p_in_v = 1'b0;
    chk_cnt++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_sat got %0d want 65535", drop_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (drop_cnt !== 16'hFFFF) $display("FAIL drop_hold got %0d want 65535", drop_cnt); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL drop_rst got %0d want 0", drop_cnt); else pass_cnt++;
    tick();
    rst = 1'b0;
    bus.s_out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL timeout checks=%0d passed=%0d", chk_cnt, pass_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef PISO_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
